// File: rtl/morse_rx_fifo.sv
// Morse receiver: synchronizes the line, times marks/gaps against dot period P,
// decodes characters and queues {unknown, char} in a small FIFO.
// Optional macro MORSE_RX_PUNCT_EN adds decoding of '.', ',' and '?'.
module morse_rx_fifo #(
    parameter int PERIOD_WIDTH = 28,
    parameter int MAX_ELEMENTS = 6,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    morse_i,
    input  logic [PERIOD_WIDTH-1:0] dot_period_i,
    output logic [7:0]              char_o,
    output logic                    unknown_o,
    output logic                    char_valid_o,
    input  logic                    char_ready_i,
    output logic                    dot_period_error_o,
    output logic                    overflow_o
);

    localparam int CNT_W  = PERIOD_WIDTH + 3;
    localparam int CODE_W = (MAX_ELEMENTS > 6) ? MAX_ELEMENTS : 6;
    localparam int LEN_W  = ($clog2(MAX_ELEMENTS + 1) > 4) ? $clog2(MAX_ELEMENTS + 1) : 4;
    localparam int AW     = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Key is {element count, elements right-aligned, first element highest, dash=1}.
    function automatic logic [8:0] decode_char(input logic [3:0] len,
                                               input logic [5:0] code,
                                               input logic       overrun);
        logic [8:0] res;
        res = {1'b1, 8'h3F};
        if (overrun) begin
            res = {1'b1, 8'h3F};
        end else begin
            case ({len, code})
                {4'd2, 6'b000001}: res = {1'b0, 8'h41};
                {4'd4, 6'b001000}: res = {1'b0, 8'h42};
                {4'd4, 6'b001010}: res = {1'b0, 8'h43};
                {4'd3, 6'b000100}: res = {1'b0, 8'h44};
                {4'd1, 6'b000000}: res = {1'b0, 8'h45};
                {4'd4, 6'b000010}: res = {1'b0, 8'h46};
                {4'd3, 6'b000110}: res = {1'b0, 8'h47};
                {4'd4, 6'b000000}: res = {1'b0, 8'h48};
                {4'd2, 6'b000000}: res = {1'b0, 8'h49};
                {4'd4, 6'b000111}: res = {1'b0, 8'h4A};
                {4'd3, 6'b000101}: res = {1'b0, 8'h4B};
                {4'd4, 6'b000100}: res = {1'b0, 8'h4C};
                {4'd2, 6'b000011}: res = {1'b0, 8'h4D};
                {4'd2, 6'b000010}: res = {1'b0, 8'h4E};
                {4'd3, 6'b000111}: res = {1'b0, 8'h4F};
                {4'd4, 6'b000110}: res = {1'b0, 8'h50};
                {4'd4, 6'b001101}: res = {1'b0, 8'h51};
                {4'd3, 6'b000010}: res = {1'b0, 8'h52};
                {4'd3, 6'b000000}: res = {1'b0, 8'h53};
                {4'd1, 6'b000001}: res = {1'b0, 8'h54};
                {4'd3, 6'b000001}: res = {1'b0, 8'h55};
                {4'd4, 6'b000001}: res = {1'b0, 8'h56};
                {4'd3, 6'b000011}: res = {1'b0, 8'h57};
                {4'd4, 6'b001001}: res = {1'b0, 8'h58};
                {4'd4, 6'b001011}: res = {1'b0, 8'h59};
                {4'd4, 6'b001100}: res = {1'b0, 8'h5A};
                {4'd5, 6'b011111}: res = {1'b0, 8'h30};
                {4'd5, 6'b001111}: res = {1'b0, 8'h31};
                {4'd5, 6'b000111}: res = {1'b0, 8'h32};
                {4'd5, 6'b000011}: res = {1'b0, 8'h33};
                {4'd5, 6'b000001}: res = {1'b0, 8'h34};
                {4'd5, 6'b000000}: res = {1'b0, 8'h35};
                {4'd5, 6'b010000}: res = {1'b0, 8'h36};
                {4'd5, 6'b011000}: res = {1'b0, 8'h37};
                {4'd5, 6'b011100}: res = {1'b0, 8'h38};
                {4'd5, 6'b011110}: res = {1'b0, 8'h39};
`ifdef MORSE_RX_PUNCT_EN
                {4'd6, 6'b010101}: res = {1'b0, 8'h2E};
                {4'd6, 6'b110011}: res = {1'b0, 8'h2C};
                {4'd6, 6'b001100}: res = {1'b0, 8'h3F};
`endif
                default:           res = {1'b1, 8'h3F};
            endcase
        end
        return res;
    endfunction

    state_t                  state_r, state_n;
    logic                    sync1_r, sync2_r, sync3_r;
    logic [CNT_W-1:0]        cnt_r, cnt_n, cnt_inc_s;
    logic [PERIOD_WIDTH-1:0] p_r, p_eff_s;
    logic [CNT_W-1:0]        half_s, two_s, four_s, five_s;
    logic [CODE_W-1:0]       code_r;
    logic [LEN_W-1:0]        len_r;
    logic                    overrun_r;
    logic                    rise_s, fall_s;
    logic                    append_s, is_dash_s, clear_s, push_s, mark_err_s;
    logic [8:0]              push_data_s, decoded_s;
    logic [3:0]              key_len_s;
    logic [8:0]              mem_r [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [AW:0]             count_r;
    logic                    full_s, pop_s, accept_s;
    logic                    err_r, ovf_r;

    assign rise_s    = sync2_r & ~sync3_r;
    assign fall_s    = ~sync2_r & sync3_r;
    assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
    assign p_eff_s   = (state_r == IDLE) ? dot_period_i : p_r;
    assign half_s    = CNT_W'(p_r >> 1);
    assign two_s     = CNT_W'(p_r) << 1;
    assign four_s    = CNT_W'(p_r) << 2;
    assign five_s    = four_s + CNT_W'(p_r);
    assign key_len_s = (len_r > LEN_W'(6)) ? 4'hF : len_r[3:0];
    assign decoded_s = decode_char(key_len_s, code_r[5:0], overrun_r);

    // Line synchronizer plus one extra stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= morse_i;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // FSM state, duration counter and period latch (P tracks the input only in IDLE).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            cnt_r   <= CNT_W'(0);
            p_r     <= PERIOD_WIDTH'(0);
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            if (state_r == IDLE) begin
                p_r <= dot_period_i;
            end else begin
                p_r <= p_r;
            end
        end
    end

    // Next-state logic: mark classification and gap-driven character/space emission.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        append_s    = 1'b0;
        is_dash_s   = 1'b0;
        clear_s     = 1'b0;
        push_s      = 1'b0;
        push_data_s = 9'h000;
        mark_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s && (p_eff_s != PERIOD_WIDTH'(0))) begin
                    state_n = MARK;
                    cnt_n   = CNT_W'(1);
                end else begin
                    cnt_n   = CNT_W'(0);
                end
            end
            MARK: begin
                if (fall_s) begin
                    if ((cnt_r < half_s) || (cnt_r >= four_s)) begin
                        mark_err_s = 1'b1;
                        clear_s    = 1'b1;
                        state_n    = IDLE;
                        cnt_n      = CNT_W'(0);
                    end else begin
                        append_s   = 1'b1;
                        is_dash_s  = (cnt_r >= two_s);
                        state_n    = GAP;
                        cnt_n      = CNT_W'(1);
                    end
                end else begin
                    cnt_n = cnt_inc_s;
                end
            end
            GAP: begin
                if (rise_s) begin
                    state_n = MARK;
                    cnt_n   = CNT_W'(1);
                end else begin
                    cnt_n = cnt_inc_s;
                    if (cnt_r == five_s) begin
                        push_s      = 1'b1;
                        push_data_s = {1'b0, 8'h20};
                        state_n     = IDLE;
                        cnt_n       = CNT_W'(0);
                    end else if ((cnt_r == two_s) && (len_r != LEN_W'(0))) begin
                        push_s      = 1'b1;
                        push_data_s = decoded_s;
                        clear_s     = 1'b1;
                    end else begin
                        push_s      = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = CNT_W'(0);
            end
        endcase
    end

    // Element buffer; overrun stays set until the character is cleared.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            code_r    <= CODE_W'(0);
            len_r     <= LEN_W'(0);
            overrun_r <= 1'b0;
        end else if (clear_s) begin
            code_r    <= CODE_W'(0);
            len_r     <= LEN_W'(0);
            overrun_r <= 1'b0;
        end else if (append_s) begin
            if (len_r < LEN_W'(MAX_ELEMENTS)) begin
                code_r <= {code_r[CODE_W-2:0], is_dash_s};
                len_r  <= len_r + LEN_W'(1);
            end else begin
                overrun_r <= 1'b1;
            end
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign full_s   = (count_r == (AW+1)'(FIFO_DEPTH));
    assign pop_s    = char_valid_o & char_ready_i;
    assign accept_s = push_s & (~full_s | pop_s);

    // Character FIFO; a pop in the same cycle frees room for a push when full.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 9'h000;
            end
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + (AW+1)'(accept_s) - (AW+1)'(pop_s);
        end
    end

    // Status pulses; error also stays high while the effective period is zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            err_r <= mark_err_s | (p_eff_s == PERIOD_WIDTH'(0));
            ovf_r <= push_s & full_s & ~pop_s;
        end
    end

    assign char_valid_o       = (count_r != (AW+1)'(0));
    assign dot_period_error_o = err_r;
    assign overflow_o         = ovf_r;

    // Head of FIFO, forced to zero when empty.
    always_comb begin
        if (char_valid_o) begin
            char_o    = mem_r[rd_ptr_r][7:0];
            unknown_o = mem_r[rd_ptr_r][8];
        end else begin
            char_o    = 8'h00;
            unknown_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_morse_rx_fifo.sv
// Scoreboard bench for morse_rx_fifo with P=10 (dot 10, dash 30, element gap 10).
module tb_morse_rx_fifo;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        morse_i = 1'b0;
    logic [27:0] dot_period_i = 28'd10;
    logic        char_ready_i = 1'b1;
    logic [7:0]  char_o;
    logic        unknown_o;
    logic        char_valid_o;
    logic        dot_period_error_o;
    logic        overflow_o;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic [7:0] tbl[string];

    morse_rx_fifo dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .morse_i            (morse_i),
        .dot_period_i       (dot_period_i),
        .char_o             (char_o),
        .unknown_o          (unknown_o),
        .char_valid_o       (char_valid_o),
        .char_ready_i       (char_ready_i),
        .dot_period_error_o (dot_period_error_o),
        .overflow_o         (overflow_o)
    );

    always #5 clk = ~clk;

    // Records every pop and counts status pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (char_valid_o && char_ready_i) obs_q.push_back({unknown_o, char_o});
        if (dot_period_error_o) err_cnt <= err_cnt + 1;
        if (overflow_o) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [8:0] exp_of(input string pat);
        if (tbl.exists(pat)) return {1'b0, tbl[pat]};
        else return {1'b1, 8'h3F};
    endfunction

    // Sends a pattern; gap>=30 yields the character, gap>=60 also a space.
    task automatic send(input string pat, input int end_gap, input bit add_exp);
        byte b;
        if (add_exp && end_gap >= 30) exp_q.push_back(exp_of(pat));
        if (add_exp && end_gap >= 60) exp_q.push_back(9'h020);
        for (int i = 0; i < pat.len(); i++) begin
            b = pat[i];
            morse_i = 1'b1;
            cyc((b == 8'h2D) ? 30 : 10);
            morse_i = 1'b0;
            cyc((i == pat.len() - 1) ? end_gap : 10);
        end
    endtask

    task automatic wait_obs();
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 400) begin
            cyc(1);
            t++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        cyc(3);
        checks++;
        if ({char_o, unknown_o, char_valid_o} !== 10'h000) begin
            failures++;
            $display("FAIL reset_head: got char=%h unk=%b valid=%b, expected 00 0 0", char_o, unknown_o, char_valid_o);
        end
        checks++;
        if ({dot_period_error_o, overflow_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_pulses: got err=%b ovf=%b, expected 0 0", dot_period_error_o, overflow_o);
        end
        rst_i = 1'b1;
        cyc(5);
        checks++;
        if ({char_valid_o, dot_period_error_o} !== 2'b00) begin
            failures++;
            $display("FAIL post_reset: got valid=%b err=%b, expected 0 0", char_valid_o, dot_period_error_o);
        end
    endtask

    task automatic test_single_char();
        logic [8:0] e, o;
        send(".", 30, 1'b1);
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL single_char: got nothing, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL single_char: got %h, expected %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL single_char_extra: got %0d extra, expected 0", obs_q.size());
        end
        cyc(30);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 9'h020) begin
            failures++;
            $display("FAIL single_char_space: got %0d entries, expected one 020", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_char_space();
        logic [8:0] e, o;
        send(".-", 60, 1'b1);
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL char_space: got nothing, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL char_space: got %h, expected %h", o, e);
                end
            end
        end
        cyc(80);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL char_space_second: got %0d extra, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_mark_error();
        int base;
        base = err_cnt;
        morse_i = 1'b1; cyc(4); morse_i = 1'b0; cyc(60);
        checks++;
        if (err_cnt - base != 1 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL short_mark: got pulses=%0d pushes=%0d, expected 1 0", err_cnt - base, obs_q.size());
        end
        base = err_cnt;
        morse_i = 1'b1; cyc(45); morse_i = 1'b0; cyc(60);
        checks++;
        if (err_cnt - base != 1 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL long_mark: got pulses=%0d pushes=%0d, expected 1 0", err_cnt - base, obs_q.size());
        end
        dot_period_i = 28'd0;
        cyc(3);
        checks++;
        if (dot_period_error_o !== 1'b1) begin
            failures++;
            $display("FAIL zero_period_err: got %b, expected 1", dot_period_error_o);
        end
        morse_i = 1'b1; cyc(10); morse_i = 1'b0; cyc(60);
        checks++;
        if (obs_q.size() != 0 || dot_period_error_o !== 1'b1) begin
            failures++;
            $display("FAIL zero_period_decode: got pushes=%0d err=%b, expected 0 1", obs_q.size(), dot_period_error_o);
        end
        dot_period_i = 28'd10;
        cyc(3);
        checks++;
        if (dot_period_error_o !== 1'b0) begin
            failures++;
            $display("FAIL period_restored: got err=%b, expected 0", dot_period_error_o);
        end
        obs_q.delete();
    endtask

    // Overrun, back-to-back digits and punctuation all go through the scoreboard.
    task automatic test_patterns();
        logic [8:0] e, o;
        send("........", 60, 1'b1);
        send("-----", 30, 1'b1);
        send(".....", 60, 1'b1);
        send(".-.-.-", 60, 1'b1);
        send("--..--", 60, 1'b1);
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL patterns: got nothing, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL patterns: got %h, expected %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL patterns_extra: got %0d extra, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_overflow();
        logic [8:0] e, o;
        int base;
        base = ovf_cnt;
        char_ready_i = 1'b0;
        send(".", 30, 1'b1);
        send("-", 30, 1'b1);
        send("...", 30, 1'b1);
        send("---", 30, 1'b1);
        send("-.-", 30, 1'b0);
        checks++;
        if (ovf_cnt - base != 1 || char_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL overflow_pulse: got pulses=%0d valid=%b, expected 1 1", ovf_cnt - base, char_valid_o);
        end
        exp_q.push_back(9'h020);
        char_ready_i = 1'b1;
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL overflow_order: got nothing, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL overflow_order: got %h, expected %h", o, e);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL overflow_extra: got %0d extra, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int base;
        char_ready_i = 1'b0;
        send(".", 30, 1'b0);
        morse_i = 1'b1;
        cyc(15);
        checks++;
        if (char_valid_o !== 1'b1 || char_o !== 8'h45) begin
            failures++;
            $display("FAIL pre_reset_head: got valid=%b char=%h, expected 1 45", char_valid_o, char_o);
        end
        rst_i = 1'b0;
        morse_i = 1'b0;
        cyc(2);
        checks++;
        if ({char_o, unknown_o, char_valid_o, dot_period_error_o, overflow_o} !== 12'h000) begin
            failures++;
            $display("FAIL mid_reset_outputs: got char=%h unk=%b valid=%b err=%b ovf=%b, expected all 0",
                     char_o, unknown_o, char_valid_o, dot_period_error_o, overflow_o);
        end
        rst_i = 1'b1;
        char_ready_i = 1'b1;
        base = err_cnt;
        cyc(100);
        checks++;
        if (obs_q.size() != 0 || err_cnt != base) begin
            failures++;
            $display("FAIL post_mid_reset: got pushes=%0d err=%0d, expected 0 0", obs_q.size(), err_cnt - base);
        end
        obs_q.delete();
    endtask

    initial begin
        tbl["."] = 8'h45;      tbl["-"] = 8'h54;      tbl[".-"] = 8'h41;
        tbl["..."] = 8'h53;    tbl["---"] = 8'h4F;    tbl["-.-"] = 8'h4B;
        tbl["-----"] = 8'h30;  tbl["....."] = 8'h35;
`ifdef MORSE_RX_PUNCT_EN
        tbl[".-.-.-"] = 8'h2E; tbl["--..--"] = 8'h2C; tbl["..--.."] = 8'h3F;
`endif
        test_reset();
        test_single_char();
        test_char_space();
        test_mark_error();
        test_patterns();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
